// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bundle: decode-slot inputs, register-file
// read/write ports, execute-stage handshake and the registered ex_* payload.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        flush;
  logic        id_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [15:0] lu_stall_cnt;

  // Driver side: decode stage, register file and execute stage.
  modport master (
    output id_valid, id_instr, id_pc, rd1, rd2, wb_we, wb_rd, wb_data,
           ex_ready, flush,
    input  id_ready, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val,
           ex_rd, ex_is_load, lu_stall_cnt
  );

  // Pipeline-register side.
  modport slave (
    input  id_valid, id_instr, id_pc, rd1, rd2, wb_we, wb_rd, wb_data,
           ex_ready, flush,
    output id_ready, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val,
           ex_rd, ex_is_load, lu_stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass of the register-file
// operands, load-use hazard detection (one-cycle bubble), flush, and a
// saturating count of inserted load-use bubbles.
module id_ex_stage (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;

  logic        ex_valid_q,   ex_valid_d;
  logic [31:0] ex_pc_q,      ex_pc_d;
  logic [31:0] ex_instr_q,   ex_instr_d;
  logic [31:0] ex_rs1_val_q, ex_rs1_val_d;
  logic [31:0] ex_rs2_val_q, ex_rs2_val_d;
  logic [4:0]  ex_rd_q,      ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [15:0] stall_cnt_q,  stall_cnt_d;

  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [6:0]  id_op;
  logic        rs1_used, rs2_used;
  logic        hazard, advance;
  logic [31:0] op1_sel, op2_sel;

  // Register x0 reads as zero; a same-cycle write-back wins over the
  // (stale) register-file read data.
  function automatic logic [31:0] select_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic        we,
    input logic [4:0]  wrd,
    input logic [31:0] wdata
  );
    if (rs == 5'd0)              return 32'd0;
    else if (we && (wrd == rs))  return wdata;
    else                         return rf_data;
  endfunction

  assign id_rs1 = bus.id_instr[19:15];
  assign id_rs2 = bus.id_instr[24:20];
  assign id_op  = bus.id_instr[6:0];
  assign ex_rs1 = ex_instr_q[19:15];
  assign ex_rs2 = ex_instr_q[24:20];

  assign rs1_used = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
  assign rs2_used = (id_op == OP_REG) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

  assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && bus.id_valid &&
                  ((rs1_used && (id_rs1 == ex_rd_q)) || (rs2_used && (id_rs2 == ex_rd_q)));
  assign advance = !ex_valid_q || bus.ex_ready;

  assign op1_sel = select_operand(id_rs1, bus.rd1, bus.wb_we, bus.wb_rd, bus.wb_data);
  assign op2_sel = select_operand(id_rs2, bus.rd2, bus.wb_we, bus.wb_rd, bus.wb_data);

  // Next-state selection with priority flush > bubble > load > hold.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_instr_d   = ex_instr_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      // An empty slot always carries a NOP with rd=0 so it can never match a hazard.
      ex_valid_d   = 1'b0;
      ex_instr_d   = NOP_INSTR;
      ex_rd_d      = 5'd0;
      ex_is_load_d = 1'b0;
    end else if (advance && hazard) begin
      ex_valid_d   = 1'b0;
      ex_instr_d   = NOP_INSTR;
      ex_rd_d      = 5'd0;
      ex_is_load_d = 1'b0;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end else if (advance) begin
      ex_valid_d   = bus.id_valid;
      ex_pc_d      = bus.id_pc;
      ex_rs1_val_d = op1_sel;
      ex_rs2_val_d = op2_sel;
      if (bus.id_valid) begin
        ex_instr_d   = bus.id_instr;
        ex_rd_d      = bus.id_instr[11:7];
        ex_is_load_d = (id_op == OP_LOAD);
      end else begin
        // Empty decode slot becomes an empty execute slot (NOP, rd=0).
        ex_instr_d   = NOP_INSTR;
        ex_rd_d      = 5'd0;
        ex_is_load_d = 1'b0;
      end
    end else begin
      // Held instruction keeps its operands fresh against write-backs it would otherwise miss.
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_rs1)) ex_rs1_val_d = bus.wb_data;
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_rs2)) ex_rs2_val_d = bus.wb_data;
    end
  end

  // Pipeline registers with asynchronous active-low reset to an empty NOP slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= 32'd0;
      ex_instr_q   <= NOP_INSTR;
      ex_rs1_val_q <= 32'd0;
      ex_rs2_val_q <= 32'd0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.id_ready     = bus.flush || (advance && !hazard);
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_instr     = ex_instr_q;
  assign bus.ex_rs1_val   = ex_rs1_val_q;
  assign bus.ex_rs2_val   = ex_rs2_val_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_is_load   = ex_is_load_q;
  assign bus.lu_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the pipeline slot.
module tb_id_ex_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural picture of the execute slot.
  bit          mValid;
  logic [31:0] mPc, mInstr, mRs1, mRs2;
  logic [4:0]  mRd;
  bit          mIsLoad;
  int          mCnt;

  function automatic logic [31:0] encR(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = 32'd0;
    w[6:0]   = op;
    w[11:7]  = 5'(rd);
    w[19:15] = 5'(rs1);
    w[24:20] = 5'(rs2);
    return w;
  endfunction

  function automatic bit readsRs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit readsRs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
  endfunction

  function automatic logic [31:0] operandOf(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  function automatic bit modelHazard();
    logic [31:0] ins;
    ins = bus.id_instr;
    if (!(mValid && mIsLoad && mRd != 0 && bus.id_valid)) return 0;
    return (readsRs1(ins[6:0]) && ins[19:15] == mRd) || (readsRs2(ins[6:0]) && ins[24:20] == mRd);
  endfunction

  function automatic bit modelIdReady();
    return bus.flush || ((!mValid || bus.ex_ready) && !modelHazard());
  endfunction

  task automatic modelReset();
    mValid = 0; mPc = 0; mInstr = NOP; mRs1 = 0; mRs2 = 0; mRd = 0; mIsLoad = 0; mCnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit canMove, haz;
    canMove = !mValid || bus.ex_ready;
    haz     = modelHazard();
    if (bus.flush) begin
      mValid = 0; mInstr = NOP; mRd = 0; mIsLoad = 0;
    end else if (canMove && haz) begin
      mValid = 0; mInstr = NOP; mRd = 0; mIsLoad = 0;
      mCnt = (mCnt >= 65535) ? 65535 : mCnt + 1;
    end else if (canMove) begin
      mValid = bus.id_valid;
      if (bus.id_valid) begin
        mPc     = bus.id_pc;
        mInstr  = bus.id_instr;
        mRs1    = operandOf(bus.id_instr[19:15], bus.rd1);
        mRs2    = operandOf(bus.id_instr[24:20], bus.rd2);
        mRd     = bus.id_instr[11:7];
        mIsLoad = (bus.id_instr[6:0] == 7'b0000011);
      end else begin
        mInstr = NOP; mRd = 0; mIsLoad = 0;
      end
    end else begin
      if (bus.wb_we && bus.wb_rd != 0 && bus.wb_rd == mInstr[19:15]) mRs1 = bus.wb_data;
      if (bus.wb_we && bus.wb_rd != 0 && bus.wb_rd == mInstr[24:20]) mRs2 = bus.wb_data;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Compare the registered outputs with the model; payload only matters while valid.
  task automatic checkOutput(input string tag);
    checkVal({tag, ":ex_valid"}, 32'(bus.ex_valid), 32'(mValid));
    checkVal({tag, ":lu_stall_cnt"}, 32'(bus.lu_stall_cnt), 32'(mCnt));
    checkVal({tag, ":ex_instr"}, bus.ex_instr, mInstr);
    checkVal({tag, ":ex_rd"}, 32'(bus.ex_rd), 32'(mRd));
    if (mValid) begin
      checkVal({tag, ":ex_pc"}, bus.ex_pc, mPc);
      checkVal({tag, ":ex_rs1_val"}, bus.ex_rs1_val, mRs1);
      checkVal({tag, ":ex_rs2_val"}, bus.ex_rs2_val, mRs2);
      checkVal({tag, ":ex_is_load"}, 32'(bus.ex_is_load), 32'(mIsLoad));
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, ":ex_valid"}, 32'(bus.ex_valid), 32'd0);
    checkVal({tag, ":ex_pc"}, bus.ex_pc, 32'd0);
    checkVal({tag, ":ex_instr"}, bus.ex_instr, NOP);
    checkVal({tag, ":ex_rs1_val"}, bus.ex_rs1_val, 32'd0);
    checkVal({tag, ":ex_rs2_val"}, bus.ex_rs2_val, 32'd0);
    checkVal({tag, ":ex_rd"}, 32'(bus.ex_rd), 32'd0);
    checkVal({tag, ":ex_is_load"}, 32'(bus.ex_is_load), 32'd0);
    checkVal({tag, ":lu_stall_cnt"}, 32'(bus.lu_stall_cnt), 32'd0);
  endtask

  // Drive one cycle of inputs shortly after the falling edge.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input bit we, input int wrd, input logic [31:0] wdat,
                               input bit rdy, input bit fl);
    @(negedge clk);
    bus.id_valid = v;   bus.id_instr = ins; bus.id_pc = pc;
    bus.rd1 = r1;       bus.rd2 = r2;
    bus.wb_we = we;     bus.wb_rd = 5'(wrd); bus.wb_data = wdat;
    bus.ex_ready = rdy; bus.flush = fl;
    #1;
  endtask

  // Check the combinational id_ready, take the edge, then check registered state.
  task automatic stepCycle(input string tag);
    checkVal({tag, ":id_ready"}, 32'(bus.id_ready), 32'(modelIdReady()));
    @(posedge clk);
    modelEdge();
    #1 checkOutput(tag);
  endtask

  initial begin
    logic [6:0] opList [8] = '{7'b0110011, 7'b0000011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b0100011, 7'b1100011, 7'b0010011};
    logic [31:0] lwX5, addX6, luiX5;

    rst_n = 1'b0;
    bus.id_valid = 0; bus.id_instr = NOP; bus.id_pc = 0; bus.rd1 = 0; bus.rd2 = 0;
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 1; bus.flush = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 checkReset("reset");

    lwX5  = encR(7'b0000011, 5, 1, 0);
    addX6 = encR(7'b0110011, 6, 5, 1);
    luiX5 = {20'h00001, 5'd5, 7'b0110111};

    // Bypass from write-back; first edge after reset is a normal load.
    applyStimulus(1, encR(7'b0110011, 3, 1, 2), 32'h100, 5, 7, 1, 1, 9, 1, 0);
    rst_n = 1'b1;
    stepCycle("bypass");
    checkVal("bypass:rs1_const", bus.ex_rs1_val, 32'd9);
    checkVal("bypass:rs2_const", bus.ex_rs2_val, 32'd7);
    checkVal("bypass:rd_const", 32'(bus.ex_rd), 32'd3);

    // Register x0 is always zero, even against a write-back to x0.
    applyStimulus(1, encR(7'b0010011, 4, 0, 0), 32'h104, 32'hDEAD, 0, 1, 0, 32'h1234, 1, 0);
    stepCycle("x0");
    checkVal("x0:rs1_const", bus.ex_rs1_val, 32'd0);

    // Load-use: one bubble, then the dependent add proceeds.
    applyStimulus(1, lwX5, 32'h108, 32'h40, 0, 0, 0, 0, 1, 0);
    stepCycle("lu_load");
    applyStimulus(1, addX6, 32'h10C, 1, 2, 0, 0, 0, 1, 0);
    checkVal("lu:id_ready_low", 32'(bus.id_ready), 32'd0);
    stepCycle("lu_bubble");
    checkVal("lu:cnt_one", 32'(bus.lu_stall_cnt), 32'd1);
    applyStimulus(1, addX6, 32'h10C, 1, 2, 0, 0, 0, 1, 0);
    checkVal("lu:id_ready_high", 32'(bus.id_ready), 32'd1);
    stepCycle("lu_resume");

    // LUI writing x5 reads no register, so no hazard.
    applyStimulus(1, lwX5, 32'h110, 32'h40, 0, 0, 0, 0, 1, 0);
    stepCycle("nofalse_load");
    applyStimulus(1, luiX5, 32'h114, 0, 0, 0, 0, 0, 1, 0);
    checkVal("nofalse:id_ready", 32'(bus.id_ready), 32'd1);
    stepCycle("nofalse");
    checkVal("nofalse:cnt", 32'(bus.lu_stall_cnt), 32'd1);

    // Held instruction picks up a write-back to its rs2.
    applyStimulus(1, encR(7'b0110011, 7, 1, 4), 32'h118, 32'h11, 32'h55, 0, 0, 0, 1, 0);
    stepCycle("hold_load");
    applyStimulus(1, encR(7'b0110011, 8, 2, 3), 32'h11C, 0, 0, 1, 4, 32'hAA, 0, 0);
    stepCycle("hold_refresh");
    checkVal("hold:rs2_const", bus.ex_rs2_val, 32'hAA);
    checkVal("hold:rs1_const", bus.ex_rs1_val, 32'h11);
    checkVal("hold:pc_const", bus.ex_pc, 32'h118);

    // Flush beats a pending load-use stall.
    applyStimulus(1, lwX5, 32'h120, 0, 0, 0, 0, 0, 1, 0);
    stepCycle("flush_load");
    applyStimulus(1, addX6, 32'h124, 0, 0, 0, 0, 0, 1, 1);
    checkVal("flush:id_ready", 32'(bus.id_ready), 32'd1);
    stepCycle("flush");
    checkVal("flush:cnt_same", 32'(bus.lu_stall_cnt), 32'd1);

    // Asynchronous reset in the middle of a hold.
    applyStimulus(1, encR(7'b0110011, 9, 1, 2), 32'h128, 3, 4, 0, 0, 0, 1, 0);
    stepCycle("pre_hold");
    applyStimulus(1, encR(7'b0110011, 10, 1, 2), 32'h12C, 3, 4, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkReset("async_reset");
    applyStimulus(1, encR(7'b0110011, 11, 2, 3), 32'h200, 32'h21, 32'h31, 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    stepCycle("post_reset");

    // Saturation: preset the counter just below the limit, then cause two bubbles.
    applyStimulus(0, NOP, 0, 0, 0, 0, 0, 0, 1, 1);
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    mCnt = 65534;
    stepCycle("sat_flush");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, encR(7'b0000011, 5, 5, 0), 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0, 1, 0);
      stepCycle("sat");
    end
    checkVal("sat:cnt_ffff", 32'(bus.lu_stall_cnt), 32'hFFFF);

    // Random traffic against the model.
    applyStimulus(0, NOP, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 rst_n = 1'b0;
    modelReset();
    applyStimulus(0, NOP, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    stepCycle("rnd_start");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = opList[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 8, ins, $urandom, $urandom, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      stepCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
